// File: rtl/timer_cmd_pkg.sv
// rtl/timer_cmd_pkg.sv - Timer register map, control bits, op/state encodings and bus helpers.
// The SN_* states exist only when TIMER_CMD_SNAPSHOT_EN is defined.
package timer_cmd_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [1:0] {
    OP_START    = 2'd0,
    OP_STOP     = 2'd1,
    OP_SNAPSHOT = 2'd2,
    OP_RSVD     = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_IRQ_ACK, ST_CLR, ST_HALT, ST_PL, ST_PH, ST_GO, ST_STOP, ST_NOP
`ifdef TIMER_CMD_SNAPSHOT_EN
    , ST_SN_WR, ST_SN_RL, ST_SN_RH, ST_SN_DONE
`endif
  } state_e;

  typedef struct packed {
    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [15:0] writedata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{chipselect: 1'b0, write_n: 1'b1, address: 3'd0, writedata: 16'd0};

  function automatic bus_t bus_wr(input logic [2:0] addr, input logic [15:0] data);
    return '{chipselect: 1'b1, write_n: 1'b0, address: addr, writedata: data};
  endfunction

  // Reads present only the address; the timer returns data one cycle later.
  function automatic bus_t bus_rd(input logic [2:0] addr);
    return '{chipselect: 1'b0, write_n: 1'b1, address: addr, writedata: 16'd0};
  endfunction

  function automatic logic [15:0] ctrl_word(input logic start, input logic stop,
                                            input logic cont, input logic ito);
    logic [15:0] w;
    w             = 16'd0;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    w[CTRL_CONT]  = cont;
    w[CTRL_ITO]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/timer_cmd_sequencer.sv
// rtl/timer_cmd_sequencer.sv - Avalon-MM master sequencing interval-timer commands and servicing its IRQ.
// Define TIMER_CMD_SNAPSHOT_EN to implement the SNAPSHOT op; otherwise op 2 is a NOP.
module timer_cmd_sequencer
  import timer_cmd_pkg::*;
#(
  parameter int TICK_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [31:0]           cmd_period,
  input  logic                  cmd_continuous,
  input  logic                  cmd_irq_en,
  output logic                  snap_valid,
  output logic [31:0]           snap_value,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  busy,
  output logic [2:0]            tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [15:0]           tmr_writedata,
  input  logic [15:0]           tmr_readdata,
  input  logic                  tmr_irq
);

  state_e      state;
  bus_t        bus;
  logic [31:0] period_q;
  logic        cont_q;
  logic        ito_q;

  assign cmd_ready      = (state == ST_IDLE) && !tmr_irq && !reset;
  assign busy           = (state != ST_IDLE);
  assign tmr_chipselect = bus.chipselect;
  assign tmr_write_n    = bus.write_n;
  assign tmr_address    = bus.address;
  assign tmr_writedata  = bus.writedata;

`ifdef TIMER_CMD_SNAPSHOT_EN
  logic        snap_valid_q;
  logic [31:0] snap_value_q;
  assign snap_valid = snap_valid_q;
  assign snap_value = snap_value_q;
`else
  logic unused_readdata;
  assign unused_readdata = ^tmr_readdata;
  assign snap_valid      = 1'b0;
  assign snap_value      = 32'd0;
`endif

  // Each transition also registers the bus cycle belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bus        <= BUS_IDLE;
      tick       <= 1'b0;
      tick_count <= '0;
      period_q   <= 32'd0;
      cont_q     <= 1'b0;
      ito_q      <= 1'b0;
`ifdef TIMER_CMD_SNAPSHOT_EN
      snap_valid_q <= 1'b0;
      snap_value_q <= 32'd0;
`endif
    end else begin
      bus  <= BUS_IDLE;
      tick <= 1'b0;
`ifdef TIMER_CMD_SNAPSHOT_EN
      snap_valid_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (tmr_irq) begin
            state <= ST_IRQ_ACK;
            bus   <= bus_wr(REG_STATUS, 16'h0000);
          end else if (cmd_valid) begin
            period_q <= cmd_period;
            cont_q   <= cmd_continuous;
            ito_q    <= cmd_irq_en;
            case (op_e'(cmd_op))
              OP_START: begin
                state <= ST_CLR;
                bus   <= bus_wr(REG_STATUS, 16'h0000);
              end
              OP_STOP: begin
                state <= ST_STOP;
                bus   <= bus_wr(REG_CONTROL, ctrl_word(1'b0, 1'b1, 1'b0, 1'b0));
              end
`ifdef TIMER_CMD_SNAPSHOT_EN
              OP_SNAPSHOT: begin
                state <= ST_SN_WR;
                bus   <= bus_wr(REG_SNAP_L, 16'h0000);
              end
`endif
              default: state <= ST_NOP;
            endcase
          end
        end
        ST_IRQ_ACK: begin
          state      <= ST_IDLE;
          tick       <= 1'b1;
          tick_count <= tick_count + TICK_CNT_W'(1);
        end
        ST_CLR: begin
          state <= ST_HALT;
          bus   <= bus_wr(REG_CONTROL, ctrl_word(1'b0, 1'b1, 1'b0, 1'b0));
        end
        ST_HALT: begin
          state <= ST_PL;
          bus   <= bus_wr(REG_PERIOD_L, period_q[15:0]);
        end
        ST_PL: begin
          state <= ST_PH;
          bus   <= bus_wr(REG_PERIOD_H, period_q[31:16]);
        end
        ST_PH: begin
          state <= ST_GO;
          bus   <= bus_wr(REG_CONTROL, ctrl_word(1'b1, 1'b0, cont_q, ito_q));
        end
`ifdef TIMER_CMD_SNAPSHOT_EN
        ST_SN_WR: begin
          state <= ST_SN_RL;
          bus   <= bus_rd(REG_SNAP_L);
        end
        ST_SN_RL: begin
          state <= ST_SN_RH;
          bus   <= bus_rd(REG_SNAP_H);
        end
        ST_SN_RH: begin
          state              <= ST_SN_DONE;
          snap_value_q[15:0] <= tmr_readdata;
        end
        ST_SN_DONE: begin
          state               <= ST_IDLE;
          snap_value_q[31:16] <= tmr_readdata;
          snap_valid_q        <= 1'b1;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// tb/tb_timer_cmd_sequencer.sv - Randomized self-checking bench for timer_cmd_sequencer with a behavioural timer model.
// Snapshot expectations follow TIMER_CMD_SNAPSHOT_EN.
module tb_timer_cmd_sequencer;

  localparam int TW = 4;
  localparam logic [20:0] IDLE_BUS = {1'b0, 1'b1, 3'd0, 16'd0};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [31:0]   cmd_period = 32'd0;
  logic          cmd_continuous = 1'b0;
  logic          cmd_irq_en = 1'b0;
  logic          snap_valid;
  logic [31:0]   snap_value;
  logic          tick;
  logic [TW-1:0] tick_count;
  logic          busy;
  logic [2:0]    tmr_address;
  logic          tmr_chipselect;
  logic          tmr_write_n;
  logic [15:0]   tmr_writedata;
  logic [15:0]   tmr_readdata = 16'd0;
  logic          tmr_irq = 1'b0;

  int errors = 0;
  int checks = 0;
  int ticks_exp = 0;

  timer_cmd_sequencer #(.TICK_CNT_W(TW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
    .snap_valid(snap_valid), .snap_value(snap_value), .tick(tick), .tick_count(tick_count),
    .busy(busy), .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata),
    .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;

  // Interval-timer model: write counting, irq held until status is written, snapshot latch.
  logic        irq_set = 1'b0;
  logic [31:0] snap_src = 32'd0;
  logic [31:0] snap_held = 32'd0;
  int          wr_count = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tmr_chipselect && !tmr_write_n) begin
      wr_count <= wr_count + 1;
      if (tmr_address == 3'd0) tmr_irq <= 1'b0;
      if (tmr_address == 3'd4) snap_held <= snap_src;
    end
    if (irq_set) tmr_irq <= 1'b1;
    tmr_readdata <= (tmr_address == 3'd4) ? snap_held[15:0] :
                    (tmr_address == 3'd5) ? snap_held[31:16] : 16'd0;
  end

  typedef struct packed {
    logic        cs;
    logic        wn;
    logic [2:0]  a;
    logic [15:0] d;
    logic        bz;
    logic        tk;
    logic        sv;
    logic        rdy;
    logic [31:0] sval;
  } smp_t;
  smp_t lg [0:8191];

  always @(negedge clk)
    if (cyc < 8192)
      lg[cyc] <= {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata,
                  busy, tick, snap_valid, cmd_ready, snap_value};

  function automatic logic [20:0] bus_at(input int c);
    return {lg[c].cs, lg[c].wn, lg[c].a, lg[c].d};
  endfunction

  function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
    return {1'b1, 1'b0, a, d};
  endfunction

  function automatic logic [20:0] rd(input logic [2:0] a);
    return {1'b0, 1'b1, a, 16'd0};
  endfunction

  function automatic logic [20:0] start_ref(input logic [31:0] p, input logic c, input logic i, input int k);
    case (k)
      0: return wr(3'd0, 16'h0000);
      1: return wr(3'd1, 16'h0008);
      2: return wr(3'd2, p[15:0]);
      3: return wr(3'd3, p[31:16]);
      default: return wr(3'd1, 16'h0004 + (c ? 16'h0002 : 16'h0000) + (i ? 16'h0001 : 16'h0000));
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] p, input logic c, input logic i, output int acc);
    int n;
    n = 0;
    cmd_op = op; cmd_period = p; cmd_continuous = c; cmd_irq_en = i; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc + 1;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic raise_irq(output int r);
    irq_set = 1'b1;
    r = cyc + 1;
    @(negedge clk);
    irq_set = 1'b0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1; cmd_op = 2'd0;
    step(3);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", cmd_ready); end
    reset = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== IDLE_BUS) begin
      errors++; $display("FAIL reset_bus: got %h required %h", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, IDLE_BUS);
    end
    checks++;
    if ({busy, tick, snap_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/tick/snap_valid=%b required 000", {busy, tick, snap_valid}); end
    checks++;
    if (tick_count !== '0 || snap_value !== 32'd0) begin errors++; $display("FAIL reset_counts: tick_count=%0d snap_value=%h required 0/0", tick_count, snap_value); end
    checks++;
    if (cmd_ready !== 1'b1 || wr_count !== 0) begin errors++; $display("FAIL reset_idle: cmd_ready=%b writes=%0d required 1/0", cmd_ready, wr_count); end
  endtask

  task automatic test_start();
    int acc, w0;
    logic [31:0] p;
    logic c, i;
    for (int it = 0; it < 5; it++) begin
      p = (it == 0) ? 32'h0001_86A0 : (it == 1) ? 32'h0 : $urandom;
      c = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      i = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      w0 = wr_count;
      issue(2'd0, p, c, i, acc);
      step(7);
      if (acc < 0) continue;
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (bus_at(acc + k) !== start_ref(p, c, i, k) || lg[acc + k].bz !== 1'b1) begin
          errors++; $display("FAIL start_wr%0d: bus=%h busy=%b required bus=%h busy=1", k, bus_at(acc + k), lg[acc + k].bz, start_ref(p, c, i, k));
        end
      end
      checks++;
      if (bus_at(acc + 5) !== IDLE_BUS || lg[acc + 5].bz !== 1'b0) begin
        errors++; $display("FAIL start_end: bus=%h busy=%b required %h/0", bus_at(acc + 5), lg[acc + 5].bz, IDLE_BUS);
      end
      checks++;
      if (wr_count - w0 !== 5) begin errors++; $display("FAIL start_count: writes=%0d required 5", wr_count - w0); end
    end
  endtask

  task automatic test_irq();
    int r, w0;
    w0 = wr_count;
    for (int n = 0; n < 3; n++) begin
      raise_irq(r);
      ticks_exp++;
      step(19);
      checks++;
      if (bus_at(r + 1) !== wr(3'd0, 16'h0000)) begin errors++; $display("FAIL irq_ack%0d: bus=%h required %h", n, bus_at(r + 1), wr(3'd0, 16'h0000)); end
      checks++;
      if ({lg[r + 1].tk, lg[r + 2].tk, lg[r + 3].tk} !== 3'b010) begin
        errors++; $display("FAIL irq_tick%0d: tick pattern=%b required 010", n, {lg[r + 1].tk, lg[r + 2].tk, lg[r + 3].tk});
      end
    end
    checks++;
    if (tick_count !== TW'(ticks_exp) || wr_count - w0 !== 3) begin
      errors++; $display("FAIL irq_total: tick_count=%0d writes=%0d required %0d/3", tick_count, wr_count - w0, TW'(ticks_exp));
    end
  endtask

  task automatic test_irq_priority();
    int r, acc;
    logic [31:0] p;
    p = $urandom;
    raise_irq(r);
    cmd_op = 2'd0; cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL prio_ready: got %b required 0", cmd_ready); end
    issue(2'd0, p, 1'b0, 1'b1, acc);
    ticks_exp++;
    step(7);
    checks++;
    if (acc !== r + 3 || bus_at(r + 1) !== wr(3'd0, 16'h0000)) begin
      errors++; $display("FAIL prio_order: accept cycle=%0d ack bus=%h required %0d/%h", acc, bus_at(r + 1), r + 3, wr(3'd0, 16'h0000));
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus_at(r + 3 + k) !== start_ref(p, 1'b0, 1'b1, k)) begin
        errors++; $display("FAIL prio_start%0d: bus=%h required %h", k, bus_at(r + 3 + k), start_ref(p, 1'b0, 1'b1, k));
      end
    end
  endtask

  task automatic test_snapshot();
    int acc, w0;
    for (int it = 0; it < 3; it++) begin
      snap_src = (it == 0) ? 32'h1234_ABCD : $urandom;
      w0 = wr_count;
      issue(2'd2, $urandom, 1'b0, 1'b0, acc);
      step(7);
      if (acc < 0) continue;
`ifdef TIMER_CMD_SNAPSHOT_EN
      checks++;
      if (bus_at(acc) !== wr(3'd4, 16'h0) || bus_at(acc + 1) !== rd(3'd4) || bus_at(acc + 2) !== rd(3'd5) || bus_at(acc + 3) !== IDLE_BUS) begin
        errors++; $display("FAIL snap_bus: %h %h %h %h required %h %h %h %h", bus_at(acc), bus_at(acc + 1), bus_at(acc + 2), bus_at(acc + 3),
                            wr(3'd4, 16'h0), rd(3'd4), rd(3'd5), IDLE_BUS);
      end
      checks++;
      if ({lg[acc + 3].sv, lg[acc + 4].sv, lg[acc + 5].sv} !== 3'b010) begin
        errors++; $display("FAIL snap_pulse: snap_valid pattern=%b required 010", {lg[acc + 3].sv, lg[acc + 4].sv, lg[acc + 5].sv});
      end
      checks++;
      if (lg[acc + 4].sval !== snap_src || wr_count - w0 !== 1) begin
        errors++; $display("FAIL snap_value: got %h writes=%0d required %h/1", lg[acc + 4].sval, wr_count - w0, snap_src);
      end
`else
      checks++;
      if (bus_at(acc) !== IDLE_BUS || bus_at(acc + 1) !== IDLE_BUS || wr_count - w0 !== 0) begin
        errors++; $display("FAIL snap_nop_bus: bus=%h/%h writes=%0d required idle/0", bus_at(acc), bus_at(acc + 1), wr_count - w0);
      end
      checks++;
      if ({lg[acc].bz, lg[acc + 1].bz, lg[acc + 1].rdy} !== 3'b101) begin
        errors++; $display("FAIL snap_nop_busy: busy/busy/ready=%b required 101", {lg[acc].bz, lg[acc + 1].bz, lg[acc + 1].rdy});
      end
      checks++;
      if ((lg[acc].sv | lg[acc + 3].sv | lg[acc + 4].sv) !== 1'b0 || lg[acc + 4].sval !== 32'd0) begin
        errors++; $display("FAIL snap_nop_out: snap_valid seen=%b snap_value=%h required 0/0", lg[acc].sv | lg[acc + 3].sv | lg[acc + 4].sv, lg[acc + 4].sval);
      end
`endif
    end
  endtask

  task automatic test_stop_nop();
    int acc, w0;
    w0 = wr_count;
    issue(2'd1, $urandom, 1'b1, 1'b1, acc);
    step(4);
    checks++;
    if (bus_at(acc) !== wr(3'd1, 16'h0008) || bus_at(acc + 1) !== IDLE_BUS || {lg[acc].bz, lg[acc + 1].bz} !== 2'b10) begin
      errors++; $display("FAIL stop: bus=%h/%h busy=%b%b required %h/idle busy=10", bus_at(acc), bus_at(acc + 1), lg[acc].bz, lg[acc + 1].bz, wr(3'd1, 16'h0008));
    end
    issue(2'd3, $urandom, 1'b1, 1'b1, acc);
    step(4);
    checks++;
    if (bus_at(acc) !== IDLE_BUS || {lg[acc].bz, lg[acc].rdy, lg[acc + 1].bz, lg[acc + 1].rdy} !== 4'b1001) begin
      errors++; $display("FAIL nop: bus=%h busy/ready=%b required idle 1001", bus_at(acc), {lg[acc].bz, lg[acc].rdy, lg[acc + 1].bz, lg[acc + 1].rdy});
    end
    checks++;
    if (wr_count - w0 !== 1) begin errors++; $display("FAIL stop_nop_count: writes=%0d required 1", wr_count - w0); end
  endtask

  task automatic test_back_to_back();
    int a1, a2;
    issue(2'd1, 32'd0, 1'b0, 1'b0, a1);
    issue(2'd1, 32'd0, 1'b0, 1'b0, a2);
    step(4);
    checks++;
    if (a2 !== a1 + 2 || bus_at(a2) !== wr(3'd1, 16'h0008)) begin
      errors++; $display("FAIL back_to_back: second accept=%0d bus=%h required %0d/%h", a2, bus_at(a2), a1 + 2, wr(3'd1, 16'h0008));
    end
  endtask

  task automatic test_reset_mid();
    int acc, w0;
    logic [31:0] p;
    p = $urandom;
    issue(2'd0, p, 1'b1, 1'b0, acc);
    step(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ticks_exp = 0;
    w0 = wr_count;
    checks++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== IDLE_BUS || busy !== 1'b0 || tick_count !== '0) begin
      errors++; $display("FAIL reset_mid: bus=%h busy=%b tick_count=%0d required idle/0/0",
                         {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, busy, tick_count);
    end
    step(4);
    checks++;
    if (wr_count !== w0) begin errors++; $display("FAIL reset_mid_quiet: writes after reset=%0d required 0", wr_count - w0); end
    p = $urandom;
    issue(2'd0, p, 1'b0, 1'b0, acc);
    step(7);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bus_at(acc + k) !== ((k < 5) ? start_ref(p, 1'b0, 1'b0, k) : IDLE_BUS)) begin
        errors++; $display("FAIL reset_mid_start%0d: bus=%h required %h", k, bus_at(acc + k), (k < 5) ? start_ref(p, 1'b0, 1'b0, k) : IDLE_BUS);
      end
    end
  endtask

  task automatic test_wrap();
    int r;
    for (int n = 0; n < (1 << TW) + 1; n++) begin
      raise_irq(r);
      ticks_exp++;
      step(2);
      checks++;
      if (tick_count !== TW'(ticks_exp % (1 << TW)) || tick !== 1'b1) begin
        errors++; $display("FAIL wrap%0d: tick_count=%0d tick=%b required %0d/1", n, tick_count, tick, ticks_exp % (1 << TW));
      end
      step($urandom_range(1, 5));
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_irq();
    test_irq_priority();
    test_snapshot();
    test_stop_nop();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_cmd_sequencer.md
Name: timer_cmd_sequencer

Overview:
- Avalon-MM master that programs and services the 16-bit-register-mapped system interval timer.
- Turns single-cycle commands (start with period/mode, stop, snapshot) into ordered register-write/read sequences on the timer's s1 slave.
- Acknowledges timeout interrupts autonomously and counts them.
- Sits between the control logic or CPU-side command FIFO and the timer.

Parameters:
- TICK_CNT_W, 16: width of the serviced-timeout counter (wraps).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0=START, 1=STOP, 2=SNAPSHOT, 3=reserved
- cmd_period  in  32  START load value
- cmd_continuous  in  1  START: continuous mode
- cmd_irq_en  in  1  START: interrupt enable
- snap_valid  out  1  one-cycle pulse, snap_value valid
- snap_value  out  32  captured counter snapshot
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_CNT_W  serviced timeouts, wraps
- busy  out  1  FSM not in IDLE
- tmr_address  out  3  timer register offset
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  active-low write
- tmr_writedata  out  16  write data
- tmr_readdata  in  16  timer read data, valid one cycle after address presented
- tmr_irq  in  1  timer interrupt, level

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous, active-high.
- Timer offsets: 0=status, 1=control, 2=period_l, 3=period_h, 4=snap_l, 5=snap_h.
- Control bits: [0]=ITO, [1]=CONT, [2]=START, [3]=STOP.
- Bus idle (IDLE and all read-only cycles except address): chipselect=0, write_n=1, address=0, writedata=0.
- All tmr_* outputs are registered. One access per cycle. No wait states.
- Reset: FSM=IDLE, bus idle, cmd_ready=0 during reset, snap_valid=0, snap_value=0, tick=0, tick_count=0, busy=0.
- Reset mid-sequence aborts immediately; no further bus cycles are issued.
- cmd_ready = (state==IDLE) && !tmr_irq. Command fields are latched on accept.
- IDLE priority: tmr_irq first, then command.
- IRQ_ACK: write status (addr 0, data 0). Next cycle: tick=1, tick_count+1, return to IDLE. The timer deasserts irq by then, so there is no double count.
- START sequence, one state per cycle:
  - CLR: status write, data 0.
  - HALT: ctrl write, 0x0008.
  - PL: addr 2, period[15:0].
  - PH: addr 3, period[31:16].
  - GO: ctrl write, 0x0004 | CONT<<1 | ITO.
  - Then IDLE. Five bus cycles; busy for 5 cycles after accept.
- STOP: ctrl write 0x0008, then IDLE. One bus cycle.
- SNAPSHOT:
  - SN_WR: write addr 4, data 0.
  - SN_RL: read address 4.
  - SN_RH: address 5; capture readdata into snap_value[15:0].
  - SN_DONE: capture readdata into snap_value[31:16]; snap_valid=1.
  - Then IDLE.
- Reserved op 3: accepted, no bus traffic, one cycle in NOP, then IDLE.
- tmr_irq asserting mid-sequence is not serviced until IDLE; it is held by the timer, so it is never lost.
- cmd_period=0 is written as-is (timer free-runs reloading 0). Not rejected.
- tick_count wraps from all-ones to 0.

Optional Feature:
- TIMER_CMD_SNAPSHOT_EN defined: SNAPSHOT op implemented as above.
- Undefined: op 2 behaves as reserved (accepted, NOP). SN_* states and snap_value register are absent. snap_valid and snap_value are tied to 0.

Decomposition:
- Package timer_cmd_pkg:
  - register offset constants (STATUS..SNAP_H);
  - control bit positions;
  - op encoding enum;
  - FSM state enum.
- Single module; no sub-module is natural (the bus driver is a few registered assigns).

Test Plan:
- Reset then START period=0x0001_86A0, cont=1, ite=1 -> writes in order (0,0x0000), (1,0x0008), (2,0x86A0), (3,0x0001), (1,0x0007) on consecutive cycles. busy=1 for 5 cycles.
- Model raises tmr_irq 3 times, 20 cycles apart -> 3 status writes (0,0x0000), 3 tick pulses, tick_count=3, no extra writes.
- cmd_valid START held while tmr_irq=1 in IDLE -> cmd_ready=0; IRQ_ACK first, then START accepted.
- SNAPSHOT with model snapshot 0x1234_ABCD -> write addr 4, reads 4/5. snap_valid pulse 4 cycles after accept with snap_value=0x1234ABCD. Without macro: no bus traffic, snap_valid stays 0.
- STOP -> single write (1,0x0008). Op 3 -> no bus cycle, cmd_ready back high after 2 cycles.
- Assert reset during PL of START -> next cycle bus idle, busy=0, tick_count=0. A fresh START completes with full 5-write sequence.
